// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage
//   ID->EX operand stage of the LX32 RV32I pipeline. It drives the
//   register-file read addresses straight from the decoded instruction.
//   It resolves rs1/rs2 with EX- and WB-stage bypass and stalls on load-use
//   hazards. The instruction is registered into the ID/EX pipeline register
//   under a valid/ready handshake, with flush and saturating perf counters.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   flush                         kill in-flight/incoming instruction
//   in_valid/in_ready             upstream handshake (in_ready combinational)
//   in_pc, in_rs1/2, in_use_rs1/2,
//   in_rd, in_rd_we, in_is_load,
//   in_ctrl                       decoded instruction fields
//   addr_rs1/2, data_rs1/2        register-file asynchronous read port
//   ex_fwd_*                      EX-stage bypass source
//   wb_we, wb_rd, wb_data         writeback bypass source
//   out_valid/out_ready           downstream handshake
//   out_pc, out_rs1/2_val, out_rd,
//   out_rd_we, out_is_load,
//   out_ctrl                      registered ID/EX payload
//   stall_cnt, flush_cnt          saturating perf counters
module operand_fetch_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_we,
    input  logic              in_is_load,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        addr_rs1,
    output logic [4:0]        addr_rs2,
    input  logic [31:0]       data_rs1,
    input  logic [31:0]       data_rs2,
    input  logic              ex_fwd_valid,
    input  logic [4:0]        ex_fwd_rd,
    input  logic [31:0]       ex_fwd_data,
    input  logic              ex_fwd_is_load,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_rs1_val,
    output logic [31:0]       out_rs2_val,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       rs1_val;
        logic [31:0]       rs2_val;
        logic [4:0]        rd;
        logic              rd_we;
        logic              is_load;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    payload_t          payload_q, payload_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              ex_bypass;
    logic              hazard;
    logic              accept;
    logic [31:0]       rs1_val;
    logic [31:0]       rs2_val;

    assign addr_rs1 = in_rs1;
    assign addr_rs2 = in_rs2;

    // A load in EX has no data yet, so it is never a bypass source.
    assign ex_bypass = ex_fwd_valid && !ex_fwd_is_load;

    always_comb begin
        if (in_rs1 == 5'd0)                          rs1_val = '0;
        else if (ex_bypass && ex_fwd_rd == in_rs1)   rs1_val = ex_fwd_data;
        else if (wb_we && wb_rd == in_rs1)           rs1_val = wb_data;
        else                                         rs1_val = data_rs1;

        if (in_rs2 == 5'd0)                          rs2_val = '0;
        else if (ex_bypass && ex_fwd_rd == in_rs2)   rs2_val = ex_fwd_data;
        else if (wb_we && wb_rd == in_rs2)           rs2_val = wb_data;
        else                                         rs2_val = data_rs2;
    end

    assign hazard = in_valid && ex_fwd_valid && ex_fwd_is_load && (ex_fwd_rd != 5'd0)
                 && ((in_use_rs1 && in_rs1 == ex_fwd_rd) || (in_use_rs2 && in_rs2 == ex_fwd_rd));

    assign in_ready = !flush && !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d     = valid_q;
        payload_d   = payload_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        // Payload changes only on accept, so it stays stable under
        // backpressure and is left untouched by bubbles and flushes.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d           = 1'b1;
            payload_d.pc      = in_pc;
            payload_d.rs1_val = rs1_val;
            payload_d.rs2_val = rs2_val;
            payload_d.rd      = in_rd;
            payload_d.rd_we   = in_rd_we;
            payload_d.is_load = in_is_load;
            payload_d.ctrl    = in_ctrl;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (hazard && !flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (valid_q || in_valid) && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the payload is reset too so out_* reads zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            payload_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            payload_q   <= payload_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = payload_q.pc;
    assign out_rs1_val = payload_q.rs1_val;
    assign out_rs2_val = payload_q.rs2_val;
    assign out_rd      = payload_q.rd;
    assign out_rd_we   = payload_q.rd_we;
    assign out_is_load = payload_q.is_load;
    assign out_ctrl    = payload_q.ctrl;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

    localparam int CTRL_W = 16;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       rs1;
        logic [31:0]       rs2;
        logic [4:0]        rd;
        logic              we;
        logic              ld;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_pc = '0;
    logic [4:0]        in_rs1 = '0, in_rs2 = '0;
    logic              in_use_rs1 = 1'b0, in_use_rs2 = 1'b0;
    logic [4:0]        in_rd = '0;
    logic              in_rd_we = 1'b0, in_is_load = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [4:0]        addr_rs1, addr_rs2;
    logic [31:0]       data_rs1, data_rs2;
    logic              ex_fwd_valid = 1'b0;
    logic [4:0]        ex_fwd_rd = '0;
    logic [31:0]       ex_fwd_data = '0;
    logic              ex_fwd_is_load = 1'b0;
    logic              wb_we = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [31:0]       wb_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_pc, out_rs1_val, out_rs2_val;
    logic [4:0]        out_rd;
    logic              out_rd_we, out_is_load;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    logic [31:0] rf [32];
    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign data_rs1 = rf[addr_rs1];
    assign data_rs2 = rf[addr_rs2];

    always #5 clk = ~clk;

    operand_fetch_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2), .data_rs1(data_rs1), .data_rs2(data_rs2),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
        .ex_fwd_is_load(ex_fwd_is_load),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_is_load(out_is_load), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rising edge, then 1 time unit so inputs change away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic [CTRL_W-1:0] ctrl);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_rs1 = u1;
        in_use_rs2 = u2;
        in_rd      = rd;
        in_rd_we   = 1'b1;
        in_is_load = pc[2];
        in_ctrl    = ctrl;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [4:0] rd, input logic [CTRL_W-1:0] ctrl);
        exp_t e;
        e.pc = pc; e.rs1 = v1; e.rs2 = v2; e.rd = rd; e.we = 1'b1; e.ld = pc[2]; e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic ld);
        ex_fwd_valid = v; ex_fwd_rd = rd; ex_fwd_data = d; ex_fwd_is_load = ld;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_we = we; wb_rd = rd; wb_data = d;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        set_ex(1'b0, 5'd0, 32'd0, 1'b0);
        set_wb(1'b0, 5'd0, 32'd0);
    endtask

    // Scoreboard monitor: pops on every downstream transfer, mid-cycle.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", 128'(out_pc), 128'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e, g;
                e = sb.pop_front();
                g.pc = out_pc; g.rs1 = out_rs1_val; g.rs2 = out_rs2_val; g.rd = out_rd;
                g.we = out_rd_we; g.ld = out_is_load; g.ctrl = out_ctrl;
                check("sb_payload", 128'(g), 128'(e));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'hDEAD_0000;
        rf[5] = 32'h11;
        rf[6] = 32'h66;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_pc", 128'(out_pc), 128'd0);
        check("rst_cnts", 128'({stall_cnt, flush_cnt}), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rst_in_ready", 128'(in_ready), 128'd1);

        // Bypass priority, back-to-back with out_ready=1
        set_wb(1'b1, 5'd5, 32'h22);
        set_ex(1'b1, 5'd5, 32'h33, 1'b0);
        send(32'h100, 5'd5, 5'd0, 1'b1, 1'b1, 5'd1, 16'hA001);
        expect_out(32'h100, 32'h33, 32'h0, 5'd1, 16'hA001);
        #1 check("byp_in_ready", 128'(in_ready), 128'd1);
        tick();
        check("byp_out_valid", 128'(out_valid), 128'd1);
        check("byp_out_rs1", 128'(out_rs1_val), 128'h33);

        set_ex(1'b0, 5'd0, 32'd0, 1'b0);
        send(32'h104, 5'd5, 5'd0, 1'b1, 1'b0, 5'd2, 16'hA002);
        expect_out(32'h104, 32'h22, 32'h0, 5'd2, 16'hA002);
        tick();

        set_wb(1'b0, 5'd0, 32'd0);
        set_ex(1'b1, 5'd0, 32'h33, 1'b0);
        send(32'h108, 5'd0, 5'd6, 1'b1, 1'b1, 5'd3, 16'hA003);
        expect_out(32'h108, 32'h0, 32'h66, 5'd3, 16'hA003);
        tick();

        set_ex(1'b1, 5'd6, 32'h77, 1'b0);
        set_wb(1'b1, 5'd6, 32'h55);
        send(32'h10C, 5'd6, 5'd6, 1'b1, 1'b1, 5'd4, 16'hA004);
        expect_out(32'h10C, 32'h77, 32'h77, 5'd4, 16'hA004);
        tick();

        set_ex(1'b0, 5'd0, 32'd0, 1'b0);
        send(32'h110, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 16'hA005);
        expect_out(32'h110, 32'h11, 32'h55, 5'd5, 16'hA005);
        tick();
        idle();
        tick();
        check("idle_out_valid", 128'(out_valid), 128'd0);

        // Load-use hazard: one bubble, then WB supplies the loaded value
        set_ex(1'b1, 5'd7, 32'hBAD, 1'b1);
        send(32'h120, 5'd1, 5'd7, 1'b0, 1'b1, 5'd8, 16'hB001);
        expect_out(32'h120, 32'h1001, 32'hAB, 5'd8, 16'hB001);
        #1 check("lu_in_ready", 128'(in_ready), 128'd0);
        tick();
        check("lu_bubble", 128'(out_valid), 128'd0);
        check("lu_stall_cnt", 128'(stall_cnt), 128'd1);
        set_ex(1'b0, 5'd0, 32'd0, 1'b0);
        set_wb(1'b1, 5'd7, 32'hAB);
        #1 check("lu_clear_in_ready", 128'(in_ready), 128'd1);
        tick();
        check("lu_out_rs2", 128'(out_rs2_val), 128'hAB);
        idle();
        tick();

        // Backpressure
        out_ready = 1'b0;
        send(32'h200, 5'd5, 5'd6, 1'b1, 1'b1, 5'd9, 16'hC001);
        expect_out(32'h200, 32'h11, 32'h66, 5'd9, 16'hC001);
        tick();
        send(32'h204, 5'd6, 5'd5, 1'b1, 1'b1, 5'd10, 16'hC002);
        expect_out(32'h204, 32'h66, 32'h11, 5'd10, 16'hC002);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", 128'(in_ready), 128'd0);
            tick();
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_out_pc", 128'(out_pc), 128'h200);
            check("bp_out_rs1", 128'(out_rs1_val), 128'h11);
        end
        out_ready = 1'b1;
        #1 check("bp_release_in_ready", 128'(in_ready), 128'd1);
        tick();
        check("bp_next_pc", 128'(out_pc), 128'h204);
        idle();
        tick();

        // Flush with a valid instruction both in the register and incoming
        out_ready = 1'b0;
        send(32'h300, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 16'hD001);
        tick();
        flush = 1'b1;
        send(32'h304, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 16'hD002);
        #1 check("fl_in_ready", 128'(in_ready), 128'd0);
        tick();
        check("fl_out_valid", 128'(out_valid), 128'd0);
        check("fl_flush_cnt", 128'(flush_cnt), 128'd1);
        check("fl_payload_held", 128'(out_pc), 128'h300);
        flush = 1'b0;
        out_ready = 1'b1;
        idle();
        tick();

        // Stall counter saturation (starts at 1)
        set_ex(1'b1, 5'd9, 32'd0, 1'b1);
        send(32'h400, 5'd9, 5'd0, 1'b1, 1'b0, 5'd13, 16'hE001);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 12) check("sat_stall_mid", 128'(stall_cnt), 128'd14);
        end
        check("sat_stall_cnt", 128'(stall_cnt), 128'd15);
        check("sat_out_valid", 128'(out_valid), 128'd0);
        idle();
        tick();

        // Asynchronous reset mid-transfer drops the in-flight instruction
        out_ready = 1'b0;
        send(32'h500, 5'd5, 5'd6, 1'b1, 1'b1, 5'd14, 16'hF001);
        tick();
        check("mr_pre_valid", 128'(out_valid), 128'd1);
        idle();
        #2 rst = 1'b0;
        #1;
        check("mr_out_valid", 128'(out_valid), 128'd0);
        check("mr_cnts", 128'({stall_cnt, flush_cnt}), 128'd0);
        check("mr_out_pc", 128'(out_pc), 128'd0);
        #3 rst = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mr_in_ready", 128'(in_ready), 128'd1);
        tick();
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
